// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control unit: opcodes, ALU codes, FSM states
// and instruction field accessors.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_LDI  = 4'd3;
  localparam logic [3:0] OP_JMP  = 4'd4;
  localparam logic [3:0] OP_HALT = 4'd5;

  localparam logic [7:0] ALU_HOLD = 8'h00;
  localparam logic [7:0] ALU_ADD  = 8'h01;
  localparam logic [7:0] ALU_SUB  = 8'h02;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;

  // Instruction layout: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 10;
  localparam int RS_LSB  = 8;
  localparam int IMM_LSB = 0;

  function automatic logic [3:0] instr_opc(input logic [15:0] ir);
    return ir[OPC_LSB +: 4];
  endfunction

  function automatic logic [1:0] instr_rd(input logic [15:0] ir);
    return ir[RD_LSB +: 2];
  endfunction

  function automatic logic [1:0] instr_rs(input logic [15:0] ir);
    return ir[RS_LSB +: 2];
  endfunction

  function automatic logic [7:0] instr_imm(input logic [15:0] ir);
    return ir[IMM_LSB +: 8];
  endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// Instruction-memory and ALU bus between the control unit (master) and the
// ROM/ALU side (slave).
interface cpu_control_unit_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_data;
  logic [7:0]        alu_op;
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [DATA_W-1:0] alu_result;

  modport master (
    output imem_addr, alu_op, alu_in1, alu_in2,
    input  imem_data, alu_result
  );

  modport slave (
    input  imem_addr, alu_op, alu_in1, alu_in2,
    output imem_data, alu_result
  );
endinterface

// File: rtl/cu_regfile.sv
// 4-entry register file: one synchronous write port, three combinational
// read ports (rd operand, rs operand, debug).
module cu_regfile #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        rd_sel,
  input  logic [1:0]        rs_sel,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_reg
      logic [DATA_W-1:0] q_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg <= '0;
        end else if (we && (waddr == 2'(gi))) begin
          q_reg <= wdata;
        end
      end

      assign regs[gi] = q_reg;
    end
  endgenerate

  assign rd_data  = regs[rd_sel];
  assign rs_data  = regs[rs_sel];
  assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/WB/HALT sequencer driving the
// ALU from a 4x8 register file and writing its registered result back.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  cpu_control_unit_if.master    bus,
  output logic                  halted,
  input  logic [1:0]            dbg_sel,
  output logic [DATA_W-1:0]     dbg_data
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [15:0]       ir_reg, ir_next;

  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rd_data, rs_data;
  logic [7:0]        alu_op_c;
  logic [DATA_W-1:0] alu_in1_c, alu_in2_c;

  cu_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we & en),
    .waddr    (instr_rd(ir_reg)),
    .wdata    (rf_wdata),
    .rd_sel   (instr_rd(ir_reg)),
    .rs_sel   (instr_rs(ir_reg)),
    .dbg_sel  (dbg_sel),
    .rd_data  (rd_data),
    .rs_data  (rs_data),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FETCH;
      pc_reg    <= RESET_PC;
      ir_reg    <= 16'h0000;
    end else if (en) begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    rf_we      = 1'b0;
    rf_wdata   = DATA_W'(instr_imm(ir_reg));
    alu_op_c   = ALU_HOLD;
    alu_in1_c  = '0;
    alu_in2_c  = '0;

    unique case (state_reg)
      FETCH: state_next = DECODE;
      DECODE: begin
        // Synchronous ROM: the word for PC is on imem_data now.
        ir_next    = bus.imem_data;
        state_next = (instr_opc(bus.imem_data) == OP_HALT) ? HALT : EXEC;
      end
      EXEC: begin
        case (instr_opc(ir_reg))
          OP_ADD, OP_SUB: begin
            alu_op_c   = (instr_opc(ir_reg) == OP_ADD) ? ALU_ADD : ALU_SUB;
            alu_in1_c  = rd_data;
            alu_in2_c  = rs_data;
            state_next = WB;
          end
          OP_LDI: begin
            rf_we      = 1'b1;
            pc_next    = pc_reg + ADDR_W'(1);
            state_next = FETCH;
          end
          OP_JMP: begin
            pc_next    = ADDR_W'(instr_imm(ir_reg));
            state_next = FETCH;
          end
          default: begin
            pc_next    = pc_reg + ADDR_W'(1);
            state_next = FETCH;
          end
        endcase
      end
      WB: begin
        rf_we      = 1'b1;
        rf_wdata   = bus.alu_result;
        pc_next    = pc_reg + ADDR_W'(1);
        state_next = FETCH;
      end
      HALT: state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  assign bus.imem_addr = pc_reg;
  assign bus.alu_op    = alu_op_c;
  assign bus.alu_in1   = alu_in1_c;
  assign bus.alu_in2   = alu_in2_c;
  assign halted        = (state_reg == HALT);

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: vector table, hand sequences for stall/halt/reset/
// wrap, and random programs checked against an instruction-level ISA model.
module tb_cpu_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       halted;
  logic [1:0] dbg_sel = 2'd0;
  logic [7:0] dbg_data;

  int errors = 0;
  int checks = 0;

  cpu_control_unit_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  cpu_control_unit #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .bus      (bus),
    .halted   (halted),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  // Synchronous instruction ROM and registered ALU models
  logic [15:0] rom [256];

  always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

  always @(posedge clk) begin
    case (bus.alu_op)
      8'h01:   bus.alu_result <= bus.alu_in1 + bus.alu_in2;
      8'h02:   bus.alu_result <= bus.alu_in1 - bus.alu_in2;
      default: bus.alu_result <= bus.alu_result;
    endcase
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd_dbg(input logic [1:0] s, output logic [7:0] v);
    dbg_sel = s;
    #1;
    v = dbg_data;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b1;
    tick(2);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] i0, i1, i2;
    int          cyc;
    logic [7:0]  r0, r1, r2, r3, pc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [7:0] v;
    logic [7:0] er [4];

    vecs[0] = '{16'h3005, 16'h3403, 16'h1100, 10, 8'h08, 8'h03, 8'h00, 8'h00, 8'h03};
    vecs[1] = '{16'h3003, 16'h3408, 16'h2100, 10, 8'hFB, 8'h08, 8'h00, 8'h00, 8'h03};
    vecs[2] = '{16'h38FF, 16'h3C01, 16'h1B00, 10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h03};
    vecs[3] = '{16'h3407, 16'h1500, 16'h0000, 10, 8'h00, 8'h0E, 8'h00, 8'h00, 8'h03};
    vecs[4] = '{16'h3009, 16'h4040, 16'h0000,  6, 8'h09, 8'h00, 8'h00, 8'h00, 8'h40};
    vecs[5] = '{16'h3CAA, 16'hF3FF, 16'h7000,  9, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h03};
    vecs[6] = '{16'h3880, 16'h2A00, 16'h0000,  7, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};

    // Reset state
    clear_rom();
    rst_n = 1'b0;
    tick(3);
    check("rst_imem_addr", bus.imem_addr, 8'h00);
    check("rst_alu_op", bus.alu_op, 8'h00);
    check("rst_halted", halted, 1'b0);
    for (int s = 0; s < 4; s++) begin
      rd_dbg(2'(s), v);
      check("rst_dbg", v, 8'h00);
    end
    $display("reset state checked");

    // Vector table: short programs run for a fixed number of cycles
    for (int i = 0; i < 7; i++) begin
      clear_rom();
      rom[0] = vecs[i].i0;
      rom[1] = vecs[i].i1;
      rom[2] = vecs[i].i2;
      do_reset();
      tick(vecs[i].cyc);
      er = '{vecs[i].r0, vecs[i].r1, vecs[i].r2, vecs[i].r3};
      for (int s = 0; s < 4; s++) begin
        rd_dbg(2'(s), v);
        check("vec_reg", v, er[s]);
      end
      check("vec_pc", bus.imem_addr, vecs[i].pc);
      $display("vector %0d: %h %h %h after %0d cycles", i, vecs[i].i0, vecs[i].i1, vecs[i].i2, vecs[i].cyc);
    end

    // Main program: LDI, LDI, ADD, SUB, JMP 0
    clear_rom();
    rom[0] = 16'h3005; rom[1] = 16'h3403; rom[2] = 16'h1100;
    rom[3] = 16'h2400; rom[4] = 16'h4000;
    do_reset();
    tick(8);
    check("add_exec_op", bus.alu_op, 8'h01);
    check("add_exec_in1", bus.alu_in1, 8'h05);
    check("add_exec_in2", bus.alu_in2, 8'h03);
    tick(1);
    check("wb_alu_op", bus.alu_op, 8'h00);
    tick(1);
    rd_dbg(2'd0, v);
    check("add_r0", v, 8'h08);
    check("add_pc", bus.imem_addr, 8'h03);
    tick(4);
    rd_dbg(2'd1, v);
    check("sub_r1", v, 8'hFB);
    tick(3);
    check("jmp_pc", bus.imem_addr, 8'h00);
    tick(3);
    rd_dbg(2'd0, v);
    check("reload_r0", v, 8'h05);
    $display("main program sequence done");

    // Stall in ADD EXEC
    do_reset();
    tick(8);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("stall_alu_op", bus.alu_op, 8'h01);
      check("stall_pc", bus.imem_addr, 8'h02);
      rd_dbg(2'd0, v);
      check("stall_r0", v, 8'h05);
    end
    en = 1'b1;
    tick(2);
    rd_dbg(2'd0, v);
    check("resume_r0", v, 8'h08);
    check("resume_pc", bus.imem_addr, 8'h03);
    $display("enable stall sequence done");

    // HALT reached through JMP 5
    clear_rom();
    rom[0] = 16'h30AA; rom[1] = 16'h4005; rom[5] = 16'h5000;
    do_reset();
    tick(6);
    check("halt_fetch_pc", bus.imem_addr, 8'h05);
    tick(1);
    check("halt_not_yet", halted, 1'b0);
    tick(1);
    check("halt_set", halted, 1'b1);
    tick(20);
    check("halt_hold", halted, 1'b1);
    check("halt_pc", bus.imem_addr, 8'h05);
    rd_dbg(2'd0, v);
    check("halt_r0", v, 8'hAA);
    $display("halt sequence done");

    // Reset asserted during WB of ADD
    clear_rom();
    rom[0] = 16'h3005; rom[1] = 16'h3403; rom[2] = 16'h1100;
    do_reset();
    tick(9);
    rst_n = 1'b0;
    #1;
    check("midwb_pc", bus.imem_addr, 8'h00);
    tick(1);
    rd_dbg(2'd0, v);
    check("midwb_r0", v, 8'h00);
    rd_dbg(2'd1, v);
    check("midwb_r1", v, 8'h00);
    rst_n = 1'b1;
    tick(1);
    check("midwb_after_pc", bus.imem_addr, 8'h00);
    $display("reset during WB done");

    // PC wrap on NOP at 0xFF
    clear_rom();
    rom[0] = 16'h40FF;
    do_reset();
    tick(3);
    check("wrap_at_ff", bus.imem_addr, 8'hFF);
    tick(3);
    check("wrap_to_00", bus.imem_addr, 8'h00);
    $display("pc wrap done");

    // Random programs against an instruction-level model with random stalls
    for (int t = 0; t < 8; t++) begin
      logic [7:0]  m_regs [4];
      logic [7:0]  m_pc;
      logic [15:0] ins;
      logic [3:0]  opc;
      logic [1:0]  rd, rs, sel;
      logic [7:0]  imm;
      int          lat, cnt, ninstr;
      for (int a = 0; a < 256; a++) rom[a] = 16'($urandom);
      m_regs = '{8'h00, 8'h00, 8'h00, 8'h00};
      m_pc   = 8'h00;
      ninstr = 0;
      do_reset();
      for (int n = 0; n < 40; n++) begin
        ins = rom[m_pc];
        opc = ins[15:12];
        rd  = ins[11:10];
        rs  = ins[9:8];
        imm = ins[7:0];
        lat = (opc == 4'd1 || opc == 4'd2) ? 4 : (opc == 4'd5) ? 2 : 3;
        cnt = 0;
        for (int g = 0; g < 200 && cnt < lat; g++) begin
          en = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (en) cnt++;
        end
        en = 1'b1;
        ninstr++;
        case (opc)
          4'd1:    begin m_regs[rd] = m_regs[rd] + m_regs[rs]; m_pc = m_pc + 8'd1; end
          4'd2:    begin m_regs[rd] = m_regs[rd] - m_regs[rs]; m_pc = m_pc + 8'd1; end
          4'd3:    begin m_regs[rd] = imm; m_pc = m_pc + 8'd1; end
          4'd4:    m_pc = imm;
          4'd5:    ;
          default: m_pc = m_pc + 8'd1;
        endcase
        check("rnd_pc", bus.imem_addr, m_pc);
        check("rnd_halted", halted, (opc == 4'd5));
        sel = 2'($urandom_range(0, 3));
        rd_dbg(sel, v);
        check("rnd_reg", v, m_regs[sel]);
        if (opc == 4'd5) break;
        check("rnd_alu_idle", bus.alu_op, 8'h00);
      end
      for (int s = 0; s < 4; s++) begin
        rd_dbg(2'(s), v);
        check("rnd_final_reg", v, m_regs[s]);
      end
      $display("random trial %0d: %0d instructions", t, ninstr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
